// File: rtl/axi_rd_arbiter.sv
// Two-master AXI4-Lite read arbiter: IFU (m0) and LSU (m1) share one slave read port.
// One transaction is in flight at a time, and the grant is held from AR acceptance through the R beat.
module axi_rd_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ROUND_ROBIN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic              grant,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic RR_EN = (ROUND_ROBIN != 0);

  state_t            state_r;
  state_t            state_next_s;
  logic              grant_r;
  logic              grant_next_s;
  logic              last_served_r;
  logic              last_next_s;
  logic              sel_arvalid_s;
  logic              sel_rready_s;
  logic [ADDR_W-1:0] sel_araddr_s;

  // Request-side signals of whichever master currently owns the grant
  always_comb begin
    if (grant_r) begin
      sel_arvalid_s = m1_arvalid;
      sel_araddr_s  = m1_araddr;
      sel_rready_s  = m1_rready;
    end else begin
      sel_arvalid_s = m0_arvalid;
      sel_araddr_s  = m0_araddr;
      sel_rready_s  = m0_rready;
    end
  end

  // State, owner and fairness history registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      grant_r       <= 1'b0;
      last_served_r <= 1'b1;
    end else begin
      state_r       <= state_next_s;
      grant_r       <= grant_next_s;
      last_served_r <= last_next_s;
    end
  end

  // Next-state, arbitration and completion bookkeeping
  always_comb begin
    state_next_s = state_r;
    grant_next_s = grant_r;
    last_next_s  = last_served_r;
    case (state_r)
      IDLE: begin
        if (m0_arvalid && m1_arvalid) begin
          state_next_s = ADDR;
          grant_next_s = RR_EN ? ~last_served_r : 1'b1;
        end else if (m0_arvalid || m1_arvalid) begin
          state_next_s = ADDR;
          grant_next_s = m1_arvalid;
        end else begin
          state_next_s = IDLE;
        end
      end
      ADDR: begin
        // A withdrawn request is abandoned without reaching the slave
        if (!sel_arvalid_s) begin
          state_next_s = IDLE;
        end else if (s_arready) begin
          state_next_s = DATA;
        end else begin
          state_next_s = ADDR;
        end
      end
      DATA: begin
        if (s_rvalid && sel_rready_s) begin
          last_next_s  = grant_r;
          state_next_s = IDLE;
        end else begin
          state_next_s = DATA;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Channel routing: only the granted master is connected, everything else reads zero
  always_comb begin
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    m0_rdata   = {DATA_W{1'b0}};
    m1_rdata   = {DATA_W{1'b0}};
    m0_rresp   = 2'b00;
    m1_rresp   = 2'b00;
    s_arvalid  = 1'b0;
    s_araddr   = {ADDR_W{1'b0}};
    s_rready   = 1'b0;
    case (state_r)
      ADDR: begin
        s_arvalid = sel_arvalid_s;
        s_araddr  = sel_araddr_s;
        if (grant_r) begin
          m1_arready = s_arready;
        end else begin
          m0_arready = s_arready;
        end
      end
      DATA: begin
        s_rready = sel_rready_s;
        if (grant_r) begin
          m1_rvalid = s_rvalid;
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
        end else begin
          m0_rvalid = s_rvalid;
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
        end
      end
      default: begin
        s_arvalid = 1'b0;
      end
    endcase
  end

  assign grant = grant_r;
  assign busy  = (state_r != IDLE);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: a round-robin and a fixed-priority instance share stimulus,
// and a behavioural slave plus tie-rule model check routing, ordering and timing.
module tb_axi_rd_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] m0_araddr, m1_araddr;
  logic        m0_arvalid, m1_arvalid, m0_rready, m1_rready;
  logic        s_arready, s_rvalid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;

  // index 0: ROUND_ROBIN=1 instance, index 1: ROUND_ROBIN=0 instance
  logic [1:0]        m0_arready_o, m1_arready_o, m0_rvalid_o, m1_rvalid_o;
  logic [1:0]        s_arvalid_o, s_rready_o, grant_o, busy_o;
  logic [1:0][31:0]  m0_rdata_o, m1_rdata_o, s_araddr_o;
  logic [1:0][1:0]   m0_rresp_o, m1_rresp_o;

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(1)) u_rr (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready_o[0]),
    .m0_rdata(m0_rdata_o[0]), .m0_rresp(m0_rresp_o[0]), .m0_rvalid(m0_rvalid_o[0]), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready_o[0]),
    .m1_rdata(m1_rdata_o[0]), .m1_rresp(m1_rresp_o[0]), .m1_rvalid(m1_rvalid_o[0]), .m1_rready(m1_rready),
    .s_araddr(s_araddr_o[0]), .s_arvalid(s_arvalid_o[0]), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready_o[0]),
    .grant(grant_o[0]), .busy(busy_o[0])
  );

  axi_rd_arbiter #(.ADDR_W(32), .DATA_W(32), .ROUND_ROBIN(0)) u_fp (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready_o[1]),
    .m0_rdata(m0_rdata_o[1]), .m0_rresp(m0_rresp_o[1]), .m0_rvalid(m0_rvalid_o[1]), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready_o[1]),
    .m1_rdata(m1_rdata_o[1]), .m1_rresp(m1_rresp_o[1]), .m1_rvalid(m1_rvalid_o[1]), .m1_rready(m1_rready),
    .s_araddr(s_araddr_o[1]), .s_arvalid(s_arvalid_o[1]), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready_o[1]),
    .grant(grant_o[1]), .busy(busy_o[1])
  );

  int passed = 0;
  int total  = 0;
  int dsel   = 0;
  int model_last = 1;

  // results of the most recent transaction
  int          r_master, r_busy, r_idle;
  logic [31:0] r_addr, r_rdata;
  logic [1:0]  r_rresp;
  bit          r_leak, r_unstable, r_timeout;

  // tie rule: round-robin favours the master not served last, fixed priority favours LSU
  function automatic int tie_winner(input int sel);
    return (sel == 1) ? 1 : 1 - model_last;
  endfunction

  task automatic clear_inputs();
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    m0_rready  = 1'b1; m1_rready  = 1'b1;
    s_arready  = 1'b0; s_rvalid   = 1'b0;
    s_rdata    = 32'h0; s_rresp   = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_last = 1;
  endtask

  // Slave model serving one transaction; records what the selected instance delivered
  task automatic do_txn(input int ar_delay, input int r_delay, input logic [31:0] rdata,
                        input logic [1:0] rresp, input int late_m);
    int  ar_cnt, r_cnt, cyc;
    bit  ar_done, done, drop0, drop1, seen_ar;
    logic g0, other;
    ar_cnt = 0; r_cnt = 0; cyc = 0;
    ar_done = 1'b0; done = 1'b0; drop0 = 1'b0; drop1 = 1'b0; seen_ar = 1'b0; g0 = 1'b0;
    r_master = -1; r_busy = 0; r_idle = 0; r_addr = 32'h0; r_rdata = 32'h0; r_rresp = 2'b00;
    r_leak = 1'b0; r_unstable = 1'b0; r_timeout = 1'b0;
    while (!done && cyc < 60) begin
      if (drop0) begin m0_arvalid = 1'b0; drop0 = 1'b0; end
      if (drop1) begin m1_arvalid = 1'b0; drop1 = 1'b0; end
      if (cyc == 1 && late_m == 0) m0_arvalid = 1'b1;
      if (cyc == 1 && late_m == 1) m1_arvalid = 1'b1;
      s_arready = !ar_done && (ar_cnt >= ar_delay);
      s_rvalid  = ar_done && (r_cnt >= r_delay);
      s_rdata   = ar_done ? rdata : 32'h0;
      s_rresp   = ar_done ? rresp : 2'b00;
      #1;
      if (busy_o[dsel]) r_busy++; else r_idle++;
      if (!busy_o[dsel] && (s_arvalid_o[dsel] || s_rready_o[dsel] || m0_arready_o[dsel] ||
          m1_arready_o[dsel] || m0_rvalid_o[dsel] || m1_rvalid_o[dsel])) r_leak = 1'b1;
      if (busy_o[dsel]) begin
        other = ~grant_o[dsel];
        if (!other && (m0_arready_o[dsel] || m0_rvalid_o[dsel] || m0_rdata_o[dsel] != 32'h0 ||
            m0_rresp_o[dsel] != 2'b00)) r_leak = 1'b1;
        if (other && (m1_arready_o[dsel] || m1_rvalid_o[dsel] || m1_rdata_o[dsel] != 32'h0 ||
            m1_rresp_o[dsel] != 2'b00)) r_leak = 1'b1;
      end
      if (s_arvalid_o[dsel]) begin
        if (!seen_ar) begin
          seen_ar = 1'b1; r_addr = s_araddr_o[dsel]; g0 = grant_o[dsel];
        end else if (s_araddr_o[dsel] !== r_addr) begin
          r_unstable = 1'b1;
        end
      end
      if (seen_ar && busy_o[dsel] && grant_o[dsel] !== g0) r_unstable = 1'b1;
      if (m0_arvalid && m0_arready_o[dsel]) drop0 = 1'b1;
      if (m1_arvalid && m1_arready_o[dsel]) drop1 = 1'b1;
      if (ar_done) begin
        if (m0_rvalid_o[dsel] && m0_rready) begin
          r_master = 0; r_rdata = m0_rdata_o[dsel]; r_rresp = m0_rresp_o[dsel];
        end else if (m1_rvalid_o[dsel] && m1_rready) begin
          r_master = 1; r_rdata = m1_rdata_o[dsel]; r_rresp = m1_rresp_o[dsel];
        end
        if (s_rvalid && s_rready_o[dsel]) done = 1'b1; else r_cnt++;
      end else if (s_arvalid_o[dsel] && s_arready) begin
        ar_done = 1'b1;
      end else if (s_arvalid_o[dsel]) begin
        ar_cnt++;
      end
      @(negedge clk);
      cyc++;
    end
    r_timeout = !done;
    if (drop0) m0_arvalid = 1'b0;
    if (drop1) m1_arvalid = 1'b0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = 32'h0; s_rresp = 2'b00;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    m0_arvalid = 1'b1;
    m0_araddr  = 32'h8000_0000;
    @(negedge clk);
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({busy_o[i], s_arvalid_o[i], s_rready_o[i], grant_o[i], m0_arready_o[i], m1_arready_o[i],
           m0_rvalid_o[i], m1_rvalid_o[i]} !== 8'h00)
        $display("FAIL reset_ctrl inst%0d got busy=%b sarv=%b srr=%b grant=%b arr=%b%b rv=%b%b want all 0", i,
                 busy_o[i], s_arvalid_o[i], s_rready_o[i], grant_o[i], m0_arready_o[i], m1_arready_o[i],
                 m0_rvalid_o[i], m1_rvalid_o[i]);
      else passed++;
      total++;
      if ({s_araddr_o[i], m0_rdata_o[i], m1_rdata_o[i], m0_rresp_o[i], m1_rresp_o[i]} !== 100'h0)
        $display("FAIL reset_data inst%0d got araddr=%h rdata=%h/%h rresp=%b/%b want 0", i, s_araddr_o[i],
                 m0_rdata_o[i], m1_rdata_o[i], m0_rresp_o[i], m1_rresp_o[i]);
      else passed++;
    end
    m0_arvalid = 1'b0;
    rst = 1'b0;
    model_last = 1;
  endtask

  task automatic test_ifu_only();
    dsel = 0;
    do_reset();
    m0_araddr = 32'h8000_0000;
    m0_arvalid = 1'b1;
    do_txn(0, 1, 32'h0000_0413, 2'b00, -1);
    total++;
    if (r_master !== 0 || r_addr !== 32'h8000_0000)
      $display("FAIL ifu_route got master=%0d addr=%h want 0 80000000", r_master, r_addr);
    else passed++;
    total++;
    if (r_rdata !== 32'h0000_0413 || r_rresp !== 2'b00)
      $display("FAIL ifu_data got %h/%b want 00000413/00", r_rdata, r_rresp);
    else passed++;
    total++;
    if (r_busy != 3 || r_idle != 1)
      $display("FAIL ifu_timing got busy=%0d idle=%0d want 3 1", r_busy, r_idle);
    else passed++;
    total++;
    if ({r_leak, r_unstable, r_timeout} !== 3'b000)
      $display("FAIL ifu_protocol got leak=%b unstable=%b timeout=%b want 000", r_leak, r_unstable, r_timeout);
    else passed++;
    #1;
    total++;
    if (busy_o[0] !== 1'b0 || s_arvalid_o[0] !== 1'b0)
      $display("FAIL ifu_idle_after got busy=%b sarv=%b want 0 0", busy_o[0], s_arvalid_o[0]);
    else passed++;
    model_last = 0;
  endtask

  // Two ties in a row; expected order from the tie model
  task automatic test_tie(input int sel);
    int exp_m;
    logic [31:0] d;
    dsel = sel;
    do_reset();
    for (int round = 0; round < 2; round++) begin
      m0_araddr = 32'h8000_0004;
      m1_araddr = 32'h8000_1000;
      m0_arvalid = 1'b1;
      m1_arvalid = 1'b1;
      for (int n = 0; n < 2; n++) begin
        exp_m = (n == 0) ? tie_winner(sel) : 1 - tie_winner(sel);
        d = 32'h1000_0000 + 32'(round * 2 + n);
        do_txn(0, 0, d, 2'b00, -1);
        total++;
        if (r_master !== exp_m || r_addr !== (exp_m == 1 ? 32'h8000_1000 : 32'h8000_0004) || r_rdata !== d)
          $display("FAIL tie_order rr=%0d round%0d txn%0d got master=%0d addr=%h data=%h want master=%0d data=%h",
                   1 - sel, round, n, r_master, r_addr, r_rdata, exp_m, d);
        else passed++;
        total++;
        if ({r_leak, r_unstable, r_timeout} !== 3'b000 || r_busy != 2 || r_idle != 1)
          $display("FAIL tie_protocol rr=%0d got leak=%b unstable=%b timeout=%b busy=%0d idle=%0d want 000 2 1",
                   1 - sel, r_leak, r_unstable, r_timeout, r_busy, r_idle);
        else passed++;
        if (n == 1) model_last = exp_m;
      end
    end
  endtask

  task automatic test_slave_stall();
    dsel = 0;
    do_reset();
    m1_araddr = 32'h8000_2000;
    m1_arvalid = 1'b1;
    do_txn(4, 5, 32'h5A5A_0001, 2'b10, -1);
    total++;
    if (r_master !== 1 || r_addr !== 32'h8000_2000 || r_rresp !== 2'b10 || r_rdata !== 32'h5A5A_0001)
      $display("FAIL stall_route got master=%0d addr=%h resp=%b data=%h want 1 80002000 10 5a5a0001",
               r_master, r_addr, r_rresp, r_rdata);
    else passed++;
    total++;
    if (r_unstable !== 1'b0 || r_leak !== 1'b0 || r_timeout !== 1'b0)
      $display("FAIL stall_hold got unstable=%b leak=%b timeout=%b want 000", r_unstable, r_leak, r_timeout);
    else passed++;
    total++;
    if (r_busy != 11)
      $display("FAIL stall_timing got busy=%0d want 11", r_busy);
    else passed++;
    #1;
    total++;
    if (busy_o[0] !== 1'b0)
      $display("FAIL stall_return got busy=%b want 0", busy_o[0]);
    else passed++;
    model_last = 1;
  endtask

  task automatic test_reset_mid();
    bit found;
    dsel = 0;
    do_reset();
    m0_araddr = 32'h8000_0010;
    m0_arvalid = 1'b1;
    s_arready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      @(negedge clk);
      #1;
      if (s_rready_o[0] && busy_o[0]) found = 1'b1;
    end
    total++;
    if (!found || grant_o[0] !== 1'b0)
      $display("FAIL rstmid_reach_data got found=%b grant=%b want 1 0", found, grant_o[0]);
    else passed++;
    m0_arvalid = 1'b0;
    s_arready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (busy_o[0] !== 1'b0 || s_rready_o[0] !== 1'b0 || grant_o[0] !== 1'b0 || m0_rvalid_o[0] !== 1'b0)
      $display("FAIL rstmid_abort got busy=%b srr=%b grant=%b rv=%b want 0000", busy_o[0], s_rready_o[0],
               grant_o[0], m0_rvalid_o[0]);
    else passed++;
    rst = 1'b0;
    model_last = 1;
    m1_araddr = 32'h8000_3000;
    m1_arvalid = 1'b1;
    do_txn(1, 2, 32'hCAFE_0001, 2'b00, -1);
    total++;
    if (r_master !== 1 || r_addr !== 32'h8000_3000 || r_rdata !== 32'hCAFE_0001 || r_busy != 5 ||
        {r_leak, r_unstable, r_timeout} !== 3'b000)
      $display("FAIL rstmid_recover got master=%0d addr=%h data=%h busy=%0d flags=%b%b%b want 1 80003000 cafe0001 5 000",
               r_master, r_addr, r_rdata, r_busy, r_leak, r_unstable, r_timeout);
    else passed++;
    model_last = 1;
  endtask

  // LSU arriving one cycle late must wait even where it would win a tie
  task automatic test_late_arrival();
    dsel = 1;
    do_reset();
    m0_araddr = 32'h8000_0100;
    m1_araddr = 32'h8000_1100;
    m0_arvalid = 1'b1;
    do_txn(0, 0, 32'h0000_AAAA, 2'b00, 1);
    total++;
    if (r_master !== 0 || r_addr !== 32'h8000_0100)
      $display("FAIL late_first got master=%0d addr=%h want 0 80000100", r_master, r_addr);
    else passed++;
    do_txn(0, 0, 32'h0000_BBBB, 2'b01, -1);
    total++;
    if (r_master !== 1 || r_addr !== 32'h8000_1100 || r_rdata !== 32'h0000_BBBB || r_rresp !== 2'b01)
      $display("FAIL late_second got master=%0d addr=%h data=%h resp=%b want 1 80001100 0000bbbb 01",
               r_master, r_addr, r_rdata, r_rresp);
    else passed++;
    model_last = 1;
  endtask

  task automatic test_random(input int sel, input int iters);
    int kind, late, first, second, exp_m, ard, rd;
    logic [31:0] a0, a1, d;
    logic [1:0]  rr;
    dsel = sel;
    do_reset();
    for (int it = 0; it < iters; it++) begin
      a0 = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
      a1 = 32'h8001_0000 | ($urandom & 32'h0000_FFFC);
      m0_araddr = a0;
      m1_araddr = a1;
      kind = $urandom_range(0, 2);
      late = (kind < 2 && $urandom_range(0, 1) == 1) ? 1 - kind : -1;
      if (kind == 2) begin
        first = tie_winner(sel); second = 1 - first;
        m0_arvalid = 1'b1; m1_arvalid = 1'b1;
      end else begin
        first = kind; second = late;
        if (kind == 0) m0_arvalid = 1'b1; else m1_arvalid = 1'b1;
      end
      for (int n = 0; n < 2; n++) begin
        exp_m = (n == 0) ? first : second;
        if (exp_m >= 0) begin
          ard = $urandom_range(0, 3);
          rd  = $urandom_range(0, 3);
          d   = $urandom;
          rr  = 2'($urandom_range(0, 3));
          do_txn(ard, rd, d, rr, (n == 0) ? late : -1);
          total++;
          if (r_master !== exp_m || r_addr !== (exp_m == 1 ? a1 : a0))
            $display("FAIL rand_route sel%0d it%0d got master=%0d addr=%h want %0d %h", sel, it, r_master,
                     r_addr, exp_m, (exp_m == 1 ? a1 : a0));
          else passed++;
          total++;
          if (r_rdata !== d || r_rresp !== rr)
            $display("FAIL rand_data sel%0d it%0d got %h/%b want %h/%b", sel, it, r_rdata, r_rresp, d, rr);
          else passed++;
          total++;
          if (r_busy != 2 + ard + rd || r_idle != 1 || {r_leak, r_unstable, r_timeout} !== 3'b000)
            $display("FAIL rand_timing sel%0d it%0d got busy=%0d idle=%0d flags=%b%b%b want %0d 1 000", sel, it,
                     r_busy, r_idle, r_leak, r_unstable, r_timeout, 2 + ard + rd);
          else passed++;
          model_last = exp_m;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    m0_araddr = 32'h0;
    m1_araddr = 32'h0;
    clear_inputs();
    test_reset();
    test_ifu_only();
    test_tie(0);
    test_tie(1);
    test_slave_stall();
    test_reset_mid();
    test_late_arrival();
    test_random(0, 40);
    test_random(1, 40);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule
